// File: rtl/tess_factor_arb.sv
// tess_factor_arb
//   N_REQ hull-stage requesters share one fixed-latency tessellation-factor
//   unit. A round-robin arbiter issues at most one patch per cycle. The
//   requester ID travels alongside the patch through a tag pipe, and each
//   result is parked in a first-word-fall-through skid FIFO. A credit scheme
//   (FIFO slots minus stored results minus in-flight patches) makes sure a
//   returning result always has a slot, because the factor unit cannot stall.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   per-requester patch handshake (ready is one-hot)
//   req_coords        per-requester x0,y0..x3,y3; requester i in slice i
//   tf_valid/coords   registered issue to the shared factor unit
//   tf_done/factors   result from the unit, TF_LAT cycles after tf_valid
//   out_valid/ready   result handshake toward the primitive generator
//   out_id/factors    owning requester and its outer0..3, inner0..1
//
// Optional feature: define TESS_ARB_STATS_EN to add the saturating counters
//   stat_issued, stat_credit_stall and stat_out_stall.
module tess_factor_arb #(
    parameter int N_REQ   = 4,
    parameter int COORD_W = 16,
    parameter int TF_W    = 8,
    parameter int TF_LAT  = 2,
    parameter int FIFO_D  = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ*8*COORD_W-1:0]         req_coords,
    output logic [N_REQ-1:0]                   req_ready,
    output logic                               tf_valid,
    output logic [8*COORD_W-1:0]               tf_coords,
    input  logic                               tf_done,
    input  logic [6*TF_W-1:0]                  tf_factors,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(N_REQ)-1:0]           out_id,
    output logic [6*TF_W-1:0]                  out_factors
`ifdef TESS_ARB_STATS_EN
    ,
    output logic [31:0]                        stat_issued,
    output logic [31:0]                        stat_credit_stall,
    output logic [31:0]                        stat_out_stall
`endif
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int AW   = $clog2(FIFO_D);
    localparam int CW   = AW + 1;
    localparam int PW   = 8 * COORD_W;
    localparam int FW   = 6 * TF_W;

    // Arbitration
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any;
    logic             credit_ok;
    logic             hs;

    // Issue stage and tag pipe
    logic             tf_valid_q;
    logic [PW-1:0]    tf_coords_q;
    logic [ID_W-1:0]  iss_id_q;
    logic             tag_v_q  [TF_LAT];
    logic [ID_W-1:0]  tag_id_q [TF_LAT];
    logic [TF_LAT:0]  drain_q;

    // Result FIFO and credit bookkeeping
    logic [ID_W-1:0]  mem_id [FIFO_D];
    logic [FW-1:0]    mem_f  [FIFO_D];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    infl_q, infl_d;
    logic             empty, full, pop, push, done_v;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(FIFO_D));
    assign pop    = !empty && out_ready;
    assign done_v = tf_done && tag_v_q[TF_LAT-1];
    assign push   = done_v && (!full || pop);

    // A same-cycle pop frees one slot, so it counts as an extra credit.
    assign credit_ok = ({1'b0, cnt_q} + {1'b0, infl_q}) <
                       ((CW+1)'(FIFO_D) + (CW+1)'(pop));

    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!gnt_any && req_valid[ID_W'(idx)]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

    assign hs        = gnt_any && credit_ok && rst_n;
    assign req_ready = hs ? (N_REQ'(1) << gnt_id) : '0;
    assign rr_d      = hs ? ((gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1) : rr_q;

    assign cnt_d  = cnt_q + CW'(push) - CW'(pop);
    assign infl_d = infl_q + CW'(hs) - CW'(done_v);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q        <= '0;
            tf_valid_q  <= 1'b0;
            tf_coords_q <= '0;
            iss_id_q    <= '0;
            for (int unsigned k = 0; k < TF_LAT; k++) begin
                tag_v_q[k]  <= 1'b0;
                tag_id_q[k] <= '0;
            end
            // Results of patches issued before reset may still come back;
            // this window marks them as expected-and-ignored.
            drain_q     <= '1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            infl_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            tf_valid_q <= hs;
            if (hs) begin
                tf_coords_q <= req_coords[int'(gnt_id)*PW +: PW];
                iss_id_q    <= gnt_id;
            end
            tag_v_q[0]  <= tf_valid_q;
            tag_id_q[0] <= iss_id_q;
            for (int unsigned k = 1; k < TF_LAT; k++) begin
                tag_v_q[k]  <= tag_v_q[k-1];
                tag_id_q[k] <= tag_id_q[k-1];
            end
            drain_q <= drain_q >> 1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q  <= cnt_d;
            infl_q <= infl_d;
        end
    end

    // Storage needs no reset; out_* are forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr_q] <= tag_id_q[TF_LAT-1];
            mem_f[wr_ptr_q]  <= tf_factors;
        end
    end

    assign tf_valid    = tf_valid_q;
    assign tf_coords   = tf_coords_q;
    assign out_valid   = !empty;
    assign out_id      = empty ? '0 : mem_id[rd_ptr_q];
    assign out_factors = empty ? '0 : mem_f[rd_ptr_q];

`ifdef TESS_ARB_STATS_EN
    logic [31:0] st_iss_q, st_cred_q, st_out_q;
    logic        no_credit;

    assign no_credit = ({1'b0, cnt_q} + {1'b0, infl_q}) == (CW+1)'(FIFO_D);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_iss_q  <= '0;
            st_cred_q <= '0;
            st_out_q  <= '0;
        end else begin
            if (hs && st_iss_q != '1)
                st_iss_q <= st_iss_q + 1'b1;
            if (|req_valid && no_credit && st_cred_q != '1)
                st_cred_q <= st_cred_q + 1'b1;
            if (!empty && !out_ready && st_out_q != '1)
                st_out_q <= st_out_q + 1'b1;
        end
    end

    assign stat_issued       = st_iss_q;
    assign stat_credit_stall = st_cred_q;
    assign stat_out_stall    = st_out_q;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(done_v && full && !pop));

    a_no_orphan_done: assert property (@(posedge clk) disable iff (!rst_n)
        tf_done |-> (tag_v_q[TF_LAT-1] || (|drain_q)));

endmodule
